// File: rtl/semseg_pkg.sv
// Shared seven-segment types and constants used by the scanner and the
// character-to-segment decoders that feed it.
package semseg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        SEG_A  = 3'd0,
        SEG_B  = 3'd1,
        SEG_C  = 3'd2,
        SEG_D  = 3'd3,
        SEG_E  = 3'd4,
        SEG_F  = 3'd5,
        SEG_G  = 3'd6,
        SEG_DP = 3'd7
    } seg_bit_e;

    // Field order puts dp in bit 7 and segment a in bit 0.
    typedef struct packed {
        logic dp;
        logic g;
        logic f;
        logic e;
        logic d;
        logic c;
        logic b;
        logic a;
    } Semseg;

    typedef enum logic {
        BLINK_SHOW = 1'b0,
        BLINK_HIDE = 1'b1
    } blink_phase_e;

    function automatic logic [7:0] seg_drive(input Semseg pattern);
        logic [7:0] bits;
        bits = pattern;
        return ~bits;
    endfunction

endpackage

// File: rtl/semseg_frame_timer.sv
// Slot, digit and blink-frame timing for the scanner. Next-state values are
// exported so the top level can register outputs aligned with the counters.
module semseg_frame_timer
    import semseg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 1024,
    parameter int BLINK_FRAMES = 64,
    parameter int CNT_W        = $clog2(PRESCALE),
    parameter int IDX_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic [IDX_W-1:0] o_idx_nxt,
    output blink_phase_e     o_blink_phase_nxt,
    output logic             o_slot_start,
    output logic             o_frame_start
);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [FRM_W-1:0] r_frames;
    blink_phase_e     r_blink_phase;
    logic [FRM_W-1:0] w_frames_nxt;
    logic             w_last_digit;

    always_comb begin
        w_last_digit      = (r_idx == IDX_W'(DIGITS - 1));
        o_slot_start      = (r_cnt == CNT_W'(PRESCALE - 1));
        o_frame_start     = o_slot_start && w_last_digit;
        o_cnt_nxt         = o_slot_start ? '0 : r_cnt + 1'b1;
        o_idx_nxt         = r_idx;
        w_frames_nxt      = r_frames;
        o_blink_phase_nxt = r_blink_phase;
        if (o_slot_start) begin
            o_idx_nxt = w_last_digit ? '0 : r_idx + 1'b1;
        end
        // The blink phase flips once every BLINK_FRAMES frames.
        if (o_frame_start) begin
            if (r_frames == FRM_W'(BLINK_FRAMES - 1)) begin
                w_frames_nxt      = '0;
                o_blink_phase_nxt = (r_blink_phase == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                w_frames_nxt = r_frames + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            r_cnt         <= '0;
            r_idx         <= '0;
            r_frames      <= '0;
            r_blink_phase <= BLINK_SHOW;
        end else begin
            r_cnt         <= o_cnt_nxt;
            r_idx         <= o_idx_nxt;
            r_frames      <= w_frames_nxt;
            r_blink_phase <= o_blink_phase_nxt;
        end
    end

endmodule

// File: rtl/semseg_scanner.sv
// Multi-digit common-anode seven-segment scanner with tear-free double-buffered
// digit data, PWM brightness and per-digit blank/blink.
module semseg_scanner
    import semseg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 1024,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic [8*DIGITS-1:0] seg_i,
    input  logic [DIGITS-1:0]   blank_i,
    input  logic [DIGITS-1:0]   blink_i,
    input  logic [BRIGHT_W-1:0] brightness_i,
    input  logic                update_i,
    output logic                update_pending_o,
    output logic                frame_o,
    output logic [7:0]          seg_o,
    output logic [DIGITS-1:0]   an_o
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    blink_phase_e        w_blink_phase_nxt;
    logic                w_slot_start;
    logic                w_frame_start;

    Semseg [DIGITS-1:0]  r_stage_seg;
    Semseg [DIGITS-1:0]  r_active_seg;
    Semseg [DIGITS-1:0]  w_active_seg_nxt;
    logic [DIGITS-1:0]   r_stage_blank;
    logic [DIGITS-1:0]   r_stage_blink;
    logic [DIGITS-1:0]   r_active_blank;
    logic [DIGITS-1:0]   r_active_blink;
    logic [DIGITS-1:0]   w_active_blank_nxt;
    logic [DIGITS-1:0]   w_active_blink_nxt;
    logic                r_pending;
    logic [BRIGHT_W-1:0] r_bright;
    logic [BRIGHT_W-1:0] w_bright_nxt;
    logic [BRIGHT_W-1:0] w_phase;
    logic                w_apply;
    logic                w_pwm_on;
    logic                w_lit;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    semseg_frame_timer #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES),
        .CNT_W        (CNT_W),
        .IDX_W        (IDX_W)
    ) u_timer (
        .i_clk             (clk_i),
        .i_arstn           (arstn_i),
        .o_cnt_nxt         (w_cnt_nxt),
        .o_idx_nxt         (w_idx_nxt),
        .o_blink_phase_nxt (w_blink_phase_nxt),
        .o_slot_start      (w_slot_start),
        .o_frame_start     (w_frame_start)
    );

    // Outputs are decided from the post-edge view of every register so they
    // change on the same edge as the slot counter.
    always_comb begin
        w_apply            = w_frame_start && r_pending;
        w_active_seg_nxt   = w_apply ? r_stage_seg   : r_active_seg;
        w_active_blank_nxt = w_apply ? r_stage_blank : r_active_blank;
        w_active_blink_nxt = w_apply ? r_stage_blink : r_active_blink;
        w_bright_nxt       = w_slot_start ? brightness_i : r_bright;
        w_phase            = w_cnt_nxt[CNT_W-1 -: BRIGHT_W];
        w_pwm_on           = (&w_bright_nxt) || (w_phase < w_bright_nxt);
        w_lit              = w_pwm_on && !w_active_blank_nxt[w_idx_nxt]
                             && !(w_active_blink_nxt[w_idx_nxt] && (w_blink_phase_nxt == BLINK_HIDE));
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_stage_seg    <= '0;
            r_stage_blank  <= '0;
            r_stage_blink  <= '0;
            r_active_seg   <= '0;
            r_active_blank <= '0;
            r_active_blink <= '0;
            r_pending      <= 1'b0;
            r_bright       <= '0;
            r_seg          <= SEG_BLANK;
            r_an           <= '1;
            r_frame        <= 1'b0;
        end else begin
            if (update_i) begin
                r_stage_seg   <= seg_i;
                r_stage_blank <= blank_i;
                r_stage_blink <= blink_i;
            end
            r_active_seg   <= w_active_seg_nxt;
            r_active_blank <= w_active_blank_nxt;
            r_active_blink <= w_active_blink_nxt;
            // An update landing on a boundary edge waits for the following frame.
            r_pending      <= w_frame_start ? update_i : (r_pending || update_i);
            r_bright       <= w_bright_nxt;
            r_frame        <= w_frame_start;
            r_seg          <= w_lit ? seg_drive(w_active_seg_nxt[w_idx_nxt]) : SEG_BLANK;
            r_an           <= w_lit ? ~(DIGITS'(1) << w_idx_nxt) : '1;
        end
    end

    assign update_pending_o = r_pending;
    assign frame_o          = r_frame;
    assign seg_o            = r_seg;
    assign an_o             = r_an;

endmodule

// File: tb/tb_semseg_scanner.sv
// Bench for semseg_scanner: table vectors, hand-written corner sequences and
// random traffic, all compared every cycle against a cycle-count display model.
`timescale 1ns/1ps
module tb_semseg_scanner;
    localparam int DIGITS       = 4;
    localparam int PRESCALE     = 8;
    localparam int BRIGHT_W     = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * PRESCALE;
    localparam int NVEC         = 6;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b0;
    logic [31:0] seg_i = '0;
    logic [3:0]  blank_i = '0;
    logic [3:0]  blink_i = '0;
    logic [1:0]  brightness_i = '0;
    logic        update_i = 1'b0;
    logic        update_pending_o;
    logic        frame_o;
    logic [7:0]  seg_o;
    logic [3:0]  an_o;

    int checks = 0;
    int errors = 0;

    // Model state: elapsed edges since reset release plus the two buffers.
    int          mT;
    logic [7:0]  mStgSeg [DIGITS];
    logic [7:0]  mActSeg [DIGITS];
    logic [3:0]  mStgBlank, mStgBlink, mActBlank, mActBlink;
    logic        mPend;
    int          mBright;

    typedef struct packed {
        logic [31:0] seg;
        logic [3:0]  blank;
        logic [1:0]  bright;
        logic [31:0] expSeg;
        logic [15:0] expAn;
    } vec_t;

    vec_t vecs [NVEC];

    semseg_scanner #(
        .DIGITS       (DIGITS),
        .PRESCALE     (PRESCALE),
        .BRIGHT_W     (BRIGHT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .seg_i            (seg_i),
        .blank_i          (blank_i),
        .blink_i          (blink_i),
        .brightness_i     (brightness_i),
        .update_i         (update_i),
        .update_pending_o (update_pending_o),
        .frame_o          (frame_o),
        .seg_o            (seg_o),
        .an_o             (an_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mT = 0;
        mPend = 1'b0;
        mBright = 0;
        mStgBlank = '0;
        mStgBlink = '0;
        mActBlank = '0;
        mActBlink = '0;
        for (int k = 0; k < DIGITS; k++) begin
            mStgSeg[k] = '0;
            mActSeg[k] = '0;
        end
    endtask

    task automatic modelStep();
        if (!arstn_i) begin
            modelReset();
            return;
        end
        mT = mT + 1;
        if ((mT % FRAME) == 0 && mPend) begin
            for (int k = 0; k < DIGITS; k++) mActSeg[k] = mStgSeg[k];
            mActBlank = mStgBlank;
            mActBlink = mStgBlink;
        end
        if (update_i) begin
            for (int k = 0; k < DIGITS; k++) mStgSeg[k] = seg_i[8*k +: 8];
            mStgBlank = blank_i;
            mStgBlink = blink_i;
        end
        if ((mT % FRAME) == 0) mPend = update_i;
        else                   mPend = mPend | update_i;
        if ((mT % PRESCALE) == 0) mBright = int'(brightness_i);
    endtask

    task automatic compareModel();
        logic [7:0] eSeg;
        logic [3:0] eAn;
        logic       eFrame;
        logic       lit;
        logic       hide;
        int         cnt, idx, frm, phase;
        eSeg = 8'hFF;
        eAn = 4'hF;
        eFrame = 1'b0;
        if (mT > 0) begin
            cnt   = mT % PRESCALE;
            idx   = (mT / PRESCALE) % DIGITS;
            frm   = mT / FRAME;
            phase = cnt * (1 << BRIGHT_W) / PRESCALE;
            hide  = ((frm / BLINK_FRAMES) % 2) == 1;
            lit   = (mBright == (1 << BRIGHT_W) - 1 || phase < mBright)
                    && !mActBlank[idx] && !(mActBlink[idx] && hide);
            eFrame = (mT % FRAME) == 0;
            if (lit) begin
                eSeg = ~mActSeg[idx];
                eAn  = ~(4'b0001 << idx);
            end
        end
        checks++;
        if (seg_o !== eSeg || an_o !== eAn || frame_o !== eFrame || update_pending_o !== mPend) begin
            errors++;
            $display("[TB] FAIL cycleModel t=%0d: seg_o=%h an_o=%b frame_o=%b pending=%b, required seg_o=%h an_o=%b frame_o=%b pending=%b",
                     mT, seg_o, an_o, frame_o, update_pending_o, eSeg, eAn, eFrame, mPend);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        modelStep();
        @(negedge clk_i);
        compareModel();
    endtask

    task automatic checkValue(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eSeg, input logic [3:0] eAn);
        checks++;
        if (seg_o !== eSeg || an_o !== eAn) begin
            errors++;
            $display("[TB] FAIL %s: seg_o=%h an_o=%b, required seg_o=%h an_o=%b", name, seg_o, an_o, eSeg, eAn);
        end
    endtask

    task automatic waitFrame(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_o !== 1'b1 && n < 2 * FRAME);
        checks++;
        if (frame_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s: frame_o=%b after %0d cycles, required 1", name, frame_o, n);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] seg, input logic [3:0] blank, input logic [3:0] blink,
                                 input logic [1:0] bright, input bit doUpdate);
        seg_i = seg;
        blank_i = blank;
        blink_i = blink;
        brightness_i = bright;
        if (doUpdate) begin
            update_i = 1'b1;
            tick();
            update_i = 1'b0;
        end
    endtask

    initial begin
        int pulses, firstPulse, lastPulse, badCount, lit, outside, n;
        int litPerDigit [DIGITS];
        int multiLow;

        vecs[0] = '{32'h065B4F66, 4'b0000, 2'd3, 32'hF9A4B099, 16'h7BDE};
        vecs[1] = '{32'h3F065B4F, 4'b0100, 2'd3, 32'hC0FFA4B0, 16'h7FDE};
        vecs[2] = '{32'h807F00FF, 4'b0000, 2'd3, 32'h7F80FF00, 16'h7BDE};
        vecs[3] = '{32'h11224488, 4'b0000, 2'd1, 32'hEEDDBB77, 16'h7BDE};
        vecs[4] = '{32'h12345678, 4'b0000, 2'd0, 32'hFFFFFFFF, 16'hFFFF};
        vecs[5] = '{32'hAA55C33C, 4'b1001, 2'd2, 32'hFFAA3CFF, 16'hFBDF};

        modelReset();
        repeat (3) @(negedge clk_i);
        checkOutput("resetHeld", 8'hFF, 4'hF);
        checkValue("resetFrame", int'(frame_o), 0);
        checkValue("resetPending", int'(update_pending_o), 0);
        arstn_i = 1'b1;
        #1;
        checkValue("anodesAfterRelease", int'(an_o), 15);

        // Idle display after reset: dark, nothing pending, frame pulse every FRAME cycles.
        $display("[TB] idle after reset");
        pulses = 0;
        firstPulse = -1;
        lastPulse = -1;
        badCount = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (seg_o !== 8'hFF || an_o !== 4'hF || update_pending_o !== 1'b0) badCount++;
            if (frame_o === 1'b1) begin
                pulses++;
                if (firstPulse < 0) firstPulse = c + 1;
                lastPulse = c + 1;
            end
        end
        checkValue("idleDarkCycles", badCount, 0);
        checkValue("idleFramePulses", pulses, 3);
        checkValue("idleFirstPulse", firstPulse, 32);
        checkValue("idleLastPulse", lastPulse, 96);

        $display("[TB] table vectors");
        for (int v = 0; v < NVEC; v++) begin
            if ((mT % FRAME) == FRAME - 1) tick();
            applyStimulus(vecs[v].seg, vecs[v].blank, 4'b0000, vecs[v].bright, 1'b1);
            checkValue($sformatf("vec%0d_pendingAfterUpdate", v), int'(update_pending_o), 1);
            waitFrame($sformatf("vec%0d_apply", v));
            checkValue($sformatf("vec%0d_pendingCleared", v), int'(update_pending_o), 0);
            for (int k = 0; k < DIGITS; k++) begin
                checkOutput($sformatf("vec%0d_digit%0d", v, k), vecs[v].expSeg[8*k +: 8], vecs[v].expAn[4*k +: 4]);
                repeat (PRESCALE) tick();
            end
        end

        $display("[TB] brightness duty");
        applyStimulus(32'h065B4F66, 4'b0000, 4'b0000, 2'd1, 1'b1);
        waitFrame("bright1Apply");
        lit = 0;
        outside = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (an_o !== 4'hF) begin
                lit++;
                if ((c % PRESCALE) >= 2) outside++;
            end
            tick();
        end
        checkValue("bright1LitCycles", lit, 8);
        checkValue("bright1LitOutsideWindow", outside, 0);
        brightness_i = 2'd0;
        repeat (PRESCALE) tick();
        lit = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (an_o !== 4'hF) lit++;
            tick();
        end
        checkValue("bright0LitCycles", lit, 0);

        $display("[TB] blink and blank");
        applyStimulus(32'h065B4F66, 4'b0100, 4'b0001, 2'd3, 1'b1);
        waitFrame("blinkApply");
        for (int k = 0; k < DIGITS; k++) litPerDigit[k] = 0;
        multiLow = 0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            if ($countones(~an_o) > 1) multiLow++;
            for (int k = 0; k < DIGITS; k++) if (an_o[k] === 1'b0) litPerDigit[k]++;
            tick();
        end
        checkValue("blinkDigit0Lit", litPerDigit[0], 16);
        checkValue("blinkDigit1Lit", litPerDigit[1], 32);
        checkValue("blankDigit2Lit", litPerDigit[2], 0);
        checkValue("blinkDigit3Lit", litPerDigit[3], 32);
        checkValue("singleAnodeLow", multiLow, 0);

        $display("[TB] update on boundary edge");
        applyStimulus(32'h807F00FF, 4'b0000, 4'b0000, 2'd3, 1'b1);
        n = 0;
        while ((mT % FRAME) != FRAME - 1 && n < 2 * FRAME) begin
            tick();
            n++;
        end
        applyStimulus(32'h065B4F66, 4'b0000, 4'b0000, 2'd3, 1'b1);
        checkValue("boundaryFramePulse", int'(frame_o), 1);
        checkValue("boundaryPendingKept", int'(update_pending_o), 1);
        checkOutput("boundaryShowsA", 8'h00, 4'hE);
        waitFrame("boundaryApplyB");
        checkValue("boundaryPendingCleared", int'(update_pending_o), 0);
        checkOutput("boundaryShowsB", 8'h99, 4'hE);

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            seg_i = $urandom();
            blank_i = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0000;
            blink_i = 4'($urandom());
            if ($urandom_range(0, 7) == 0) brightness_i = 2'($urandom());
            update_i = ($urandom_range(0, 9) == 0);
            tick();
        end
        update_i = 1'b0;

        $display("[TB] reset mid-slot");
        applyStimulus(32'h065B4F66, 4'b0000, 4'b0000, 2'd3, 1'b1);
        waitFrame("resetApply");
        applyStimulus(32'h11224488, 4'b0000, 4'b0000, 2'd3, 1'b1);
        repeat (2) tick();
        checkOutput("litBeforeReset", 8'h99, 4'hE);
        checkValue("pendingBeforeReset", int'(update_pending_o), 1);
        #2 arstn_i = 1'b0;
        #1;
        checkOutput("darkDuringReset", 8'hFF, 4'hF);
        checkValue("pendingDuringReset", int'(update_pending_o), 0);
        repeat (2) tick();
        arstn_i = 1'b1;
        badCount = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (seg_o !== 8'hFF || update_pending_o !== 1'b0) badCount++;
        end
        checkValue("oldDataGoneAfterReset", badCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
